// File: rtl/alu_pkg.sv
// Shared constants, parser state type and header validation for the ALU command path.
package alu_pkg;

    localparam logic [7:0] OPC_ECHO  = 8'hEC;
    localparam logic [7:0] OPC_ADD   = 8'hAD;
    localparam logic [7:0] OPC_MUL   = 8'h88;
    localparam logic [7:0] OPC_DIV   = 8'hD4;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_OPC = 3'd0,
        HDR_RSV = 3'd1,
        HDR_LLO = 3'd2,
        HDR_LHI = 3'd3,
        PAYLOAD = 3'd4,
        DRAIN   = 3'd5
    } parser_state_e;

    // len counts the header too; arithmetic packets carry whole operand words
    function automatic logic hdr_ok(input logic [7:0] opc, input logic [15:0] len,
                                    input int word_bytes);
        logic [15:0] arith_len;
        logic [15:0] body;
        arith_len = 16'(HDR_BYTES + 2 * word_bytes);
        body      = len - 16'(HDR_BYTES);
        case (opc)
            OPC_ECHO:         hdr_ok = (len > 16'(HDR_BYTES));
            OPC_ADD, OPC_MUL: hdr_ok = (len >= arith_len) && ((body % 16'(word_bytes)) == 16'd0);
            OPC_DIV:          hdr_ok = (len == arith_len);
            default:          hdr_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_parser_if.sv
// Byte-stream input and unit-stream output of the command parser.
interface alu_cmd_parser_if #(
    parameter int DATA_WIDTH_P = 8,
    parameter int WORD_WIDTH_P = 32
);
    logic [DATA_WIDTH_P-1:0] s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic [7:0]              m_opcode_o;
    logic [WORD_WIDTH_P-1:0] m_operand_o;
    logic                    m_first_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;
    logic                    error_o;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_ready_i,
        output s_axis_tready, m_opcode_o, m_operand_o, m_first_o, m_last_o, m_valid_o, error_o
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_ready_i,
        input  s_axis_tready, m_opcode_o, m_operand_o, m_first_o, m_last_o, m_valid_o, error_o
    );
endinterface

// File: rtl/skid_reg.sv
// Single-entry valid/ready register; a new entry may load in the same cycle the old one leaves.
module skid_reg #(
    parameter int WIDTH_P = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH_P-1:0] load_data,
    output logic               load_ready,
    output logic               out_valid,
    output logic [WIDTH_P-1:0] out_data,
    input  logic               out_ready
);
    logic               valid_r;
    logic [WIDTH_P-1:0] data_r;

    assign load_ready = !valid_r || out_ready;
    assign out_valid  = valid_r;
    assign out_data   = data_r;

    // Entry register: load wins over unload, data holds while waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_parser.sv
// Frames UART bytes into opcode/length packets and streams payload units to the ALU/echo stage.
module alu_cmd_parser
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH_P = 8,
    parameter int WORD_WIDTH_P = 32
) (
    input  logic            clk,
    input  logic            rst,
    alu_cmd_parser_if.slave bus
);
    localparam int WORD_BYTES = WORD_WIDTH_P / DATA_WIDTH_P;
    localparam int CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int UNIT_W     = 8 + WORD_WIDTH_P + 2;

    parser_state_e           state_r;
    parser_state_e           state_nxt_s;
    logic [7:0]              opcode_r;
    logic [7:0]              len_lo_r;
    logic [15:0]             remaining_r;
    logic [15:0]             rem_dec_s;
    logic [15:0]             len_full_s;
    logic [CNT_W-1:0]        byte_cnt_r;
    logic [WORD_WIDTH_P-1:0] acc_r;
    logic [WORD_WIDTH_P-1:0] unit_word_s;
    logic                    first_pend_r;
    logic                    error_r;
    logic                    ready_en_r;
    logic                    hdr_ok_s;
    logic                    is_echo_s;
    logic                    unit_done_s;
    logic                    byte_take_s;
    logic                    unit_load_s;
    logic                    tready_s;
    logic                    skid_ready_s;
    logic                    skid_valid_s;
    logic [UNIT_W-1:0]       unit_in_s;
    logic [UNIT_W-1:0]       unit_out_s;

    // Byte acceptance, header check and the unit about to be formed
    always_comb begin
        len_full_s  = {bus.s_axis_tdata[7:0], len_lo_r};
        rem_dec_s   = remaining_r - 16'd1;
        hdr_ok_s    = hdr_ok(opcode_r, len_full_s, WORD_BYTES);
        is_echo_s   = (opcode_r == OPC_ECHO);
        unit_done_s = is_echo_s || (byte_cnt_r == CNT_W'(WORD_BYTES - 1));
        if (is_echo_s) begin
            unit_word_s = WORD_WIDTH_P'(bus.s_axis_tdata);
        end else begin
            unit_word_s = {bus.s_axis_tdata, acc_r[WORD_WIDTH_P-1:DATA_WIDTH_P]};
        end
        // only a unit-completing byte needs room in the output register
        tready_s    = ready_en_r && !((state_r == PAYLOAD) && unit_done_s && !skid_ready_s);
        byte_take_s = bus.s_axis_tvalid && tready_s;
        unit_load_s = byte_take_s && (state_r == PAYLOAD) && unit_done_s;
        unit_in_s   = {opcode_r, unit_word_s, first_pend_r, (rem_dec_s == 16'd0)};
    end

    // Next-state logic, advancing only on an accepted byte
    always_comb begin
        state_nxt_s = state_r;
        if (byte_take_s) begin
            case (state_r)
                HDR_OPC: state_nxt_s = HDR_RSV;
                HDR_RSV: state_nxt_s = HDR_LLO;
                HDR_LLO: state_nxt_s = HDR_LHI;
                HDR_LHI: begin
                    if (hdr_ok_s) begin
                        state_nxt_s = PAYLOAD;
                    end else if (len_full_s > 16'(HDR_BYTES)) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = HDR_OPC;
                    end
                end
                PAYLOAD, DRAIN: begin
                    if (rem_dec_s == 16'd0) begin
                        state_nxt_s = HDR_OPC;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: state_nxt_s = HDR_OPC;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= HDR_OPC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Header fields, payload counters, accumulator and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_r     <= 8'd0;
            len_lo_r     <= 8'd0;
            remaining_r  <= 16'd0;
            byte_cnt_r   <= '0;
            acc_r        <= '0;
            first_pend_r <= 1'b0;
            error_r      <= 1'b0;
            ready_en_r   <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            error_r    <= 1'b0;
            if (byte_take_s) begin
                case (state_r)
                    HDR_OPC: opcode_r <= bus.s_axis_tdata[7:0];
                    HDR_LLO: len_lo_r <= bus.s_axis_tdata[7:0];
                    HDR_LHI: begin
                        remaining_r  <= len_full_s - 16'(HDR_BYTES);
                        byte_cnt_r   <= '0;
                        first_pend_r <= hdr_ok_s;
                        error_r      <= !hdr_ok_s;
                    end
                    PAYLOAD: begin
                        remaining_r <= rem_dec_s;
                        acc_r       <= {bus.s_axis_tdata, acc_r[WORD_WIDTH_P-1:DATA_WIDTH_P]};
                        if (unit_done_s) begin
                            byte_cnt_r   <= '0;
                            first_pend_r <= 1'b0;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                        end
                    end
                    DRAIN:   remaining_r <= rem_dec_s;
                    default: begin
                    end
                endcase
            end
        end
    end

    skid_reg #(.WIDTH_P(UNIT_W)) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (unit_load_s),
        .load_data  (unit_in_s),
        .load_ready (skid_ready_s),
        .out_valid  (skid_valid_s),
        .out_data   (unit_out_s),
        .out_ready  (bus.m_ready_i)
    );

    assign bus.s_axis_tready = tready_s;
    assign bus.m_opcode_o    = unit_out_s[UNIT_W-1 -: 8];
    assign bus.m_operand_o   = unit_out_s[2 +: WORD_WIDTH_P];
    assign bus.m_first_o     = unit_out_s[1];
    assign bus.m_last_o      = unit_out_s[0];
    assign bus.m_valid_o     = skid_valid_s;
    assign bus.error_o       = error_r;

endmodule

// File: doc/alu_cmd_parser.md
Name: alu_cmd_parser

Overview:
- Sits inside top, directly downstream of the UART receiver's m_axis byte stream.
- Frames incoming bytes into command packets: opcode, reserved byte, 16-bit little-endian length, then payload.
- Forwards the opcode and payload units to the ALU/echo stage over a valid/ready stream with first/last markers.
- Flags malformed packets and discards their remaining bytes.

Parameters:
- DATA_WIDTH_P, 8, byte width of the input stream.
- WORD_WIDTH_P, 32, operand width; operands are sent little-endian, WORD_WIDTH_P/8 bytes each.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH_P  received byte from UART
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  parser accepts byte
- m_opcode_o  out  8  opcode of the current packet
- m_operand_o  out  WORD_WIDTH_P  operand word; echo bytes are zero-extended in [7:0]
- m_first_o  out  1  first unit of the packet
- m_last_o  out  1  last unit of the packet
- m_valid_o  out  1  output unit valid
- m_ready_i  in  1  downstream accepts unit
- error_o  out  1  one-cycle pulse on a malformed header

Behaviour:
- Reset values:
  - state = HDR_OPC.
  - s_axis_tready = 0 while rst is asserted, 1 in the first cycle after.
  - m_valid_o, m_first_o, m_last_o, error_o = 0.
  - m_opcode_o, m_operand_o = 0.
  - Byte counter and accumulator = 0.
- Byte transfer: a byte is taken when s_axis_tvalid && s_axis_tready. Output transfer: a unit is taken when m_valid_o && m_ready_i.
- Opcodes:
  - 0xEC echo: len >= 5; one output unit per payload byte.
  - 0xAD add, 0x88 mul: len >= 12 and (len-4) % 4 == 0; one unit per 4-byte word.
  - 0xD4 div: len == 12 exactly.
  - len counts the whole packet, including the 4 header bytes.
- States:
  - HDR_OPC: latch opcode -> HDR_RSV.
  - HDR_RSV: byte ignored -> HDR_LLO.
  - HDR_LLO: latch len[7:0] -> HDR_LHI.
  - HDR_LHI: latch len[15:8] and check opcode and length.
    - Pass: load remaining = len-4 -> PAYLOAD.
    - Fail: pulse error_o in the cycle after the accept.
      - If len > 4: remaining = len-4 -> DRAIN.
      - If len <= 4: -> HDR_OPC.
  - PAYLOAD: shift bytes into the accumulator LSB-first and decrement remaining on each byte.
    - A unit completes after 1 byte (echo) or 4 bytes (arithmetic).
    - On completion it moves into the output register. m_first_o marks the packet's first unit; m_last_o is set when remaining reaches 0.
    - At remaining == 0 -> HDR_OPC.
  - DRAIN: accept and discard bytes until remaining == 0 -> HDR_OPC. Never drive m_valid_o.
- Buffering: a single output register plus a separate byte accumulator.
  - s_axis_tready = 0 only in PAYLOAD, when the incoming byte would complete a unit and the output register is full and not being taken this cycle.
  - Otherwise s_axis_tready = 1.
- Output timing:
  - A completed unit appears on m_valid_o the cycle after its final byte is accepted.
  - m_valid_o stays high with stable data until accepted.
  - Simultaneous accept-and-reload is supported, giving full throughput of 1 unit per cycle.
- The next packet's header may be accepted while the last unit of the previous packet is still waiting in the output register.
- m_opcode_o is registered with each unit, so it cannot change under a pending unit.
- Length arithmetic is 16-bit unsigned; len = 0xFFFF for echo is legal, with 65531 units.
- Reset asserted mid-packet returns to HDR_OPC immediately and drops any pending unit. There is no recovery of the partial packet.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OPC_ECHO, OPC_ADD, OPC_MUL, OPC_DIV.
  - typedef enum for parser state.
  - HDR_BYTES = 4.
- Sub-module: one natural sub-module, skid_reg, the single-entry valid/ready output register with simultaneous load/unload. It is reusable by the ALU result path.

Test Plan:
- Echo: EC 00 07 00 41 42 43 with m_ready_i = 1 -> three units 0x41, 0x42, 0x43; first set on 0x41, last set on 0x43; opcode 0xEC on all; error_o = 0.
- Add: AD 00 0C 00 01 00 00 00 02 00 00 00 -> units 0x00000001 (first) and 0x00000002 (last); opcode 0xAD.
- Backpressure: same add packet with m_ready_i = 0 -> s_axis_tready drops when the 4th byte of word 2 is presented; m_operand_o holds 0x00000001. Raising m_ready_i -> both words delivered in order, no byte lost.
- Bad opcode: 55 00 06 00 AA BB, then EC 00 05 00 5A -> error_o pulses once; AA and BB drained with no output; the following echo yields a single unit 0x5A, first = last = 1.
- Bad length: D4 00 10 00 plus 12 payload bytes -> error_o pulse; 12 bytes drained. Also D4 00 03 00 -> error_o pulse, return to HDR_OPC with nothing drained.
- Reset mid-PAYLOAD: assert rst after 2 payload bytes of an add packet -> all outputs return to reset values, with m_valid_o = 0. A fresh echo packet afterwards parses correctly.
